queue_push_arb: RTL
===================

// Module: queue_push_arb
// PURPOSE
// - Round-robin arbiter sharing a single queue controller's push port between R requesters.
// - Owns an occupancy counter, so grants never overrun the queue.
// - Drives push/data to queue controller + SRAM write port.
// - The pop side is observed only, for credit return.
// PARAMETERS
// - R       4   number of requesters (>=2)
// - N       8   queue depth in entries (power of 2); matches queue controller N
// - W       32  payload width in bits
// - CNT_W   $clog2(N)+1  occupancy counter width (derived, do not override)
// PORTS
// - clk         in   1        clock
// - rst         in   1        synchronous, active-high reset
// - i_req_vld   in   R        per-requester valid
// - i_req_dat   in   R*W      per-requester payload; requester k at [k*W +: W]
// - i_req_last  in   R        last beat of burst (QUEUE_PUSH_ARB_BURST_EN only)
// - o_req_rdy   out  R        one-hot accept; transfer when vld&rdy
// - o_push      out  1        push strobe to queue controller
// - o_push_dat  out  W        payload of granted requester
// - o_push_src  out  $clog2(R)  index of granted requester
// - i_pop       in   1        pop strobe seen by queue controller
// - o_count     out  CNT_W    registered occupancy
// - o_full      out  1        o_count == N (registered)
// - o_empty     out  1        o_count == 0 (registered)
// - o_pop_err   out  1        sticky: pop seen while o_count == 0
// BEHAVIOUR
// - Reset values (rst=1 at clk edge): rr_ptr=0, count=0, pop_err=0, burst lock cleared.
//   - While rst is high: o_req_rdy=0 and o_push=0.
// - Grant selection:
//   - Combinational, zero latency.
//   - Winner = first k with i_req_vld[k], scanning rr_ptr, rr_ptr+1, ... mod R.
//   - o_req_rdy = onehot(winner) & ~o_full; o_push = |o_req_rdy.
//   - o_push_dat and o_push_src are taken from the winner.
//   - o_push_dat and o_push_src are don't-care when o_push=0.
// - Pointer update: on o_push, rr_ptr <= (winner+1) mod R.
//   - No push -> rr_ptr holds.
//   - R need not be a power of 2; wrap is explicit.
// - Full:
//   - No grant while o_full, even if i_pop is high that cycle (no bypass).
//   - The freed slot is usable the next cycle.
// - Count update (single adder, CNT_W bits):
//   - push & ~pop -> +1
//   - pop & ~push -> -1
//   - both or neither -> hold
// - Empty pop:
//   - i_pop while count==0 is illegal: count holds at 0 and pop_err sets.
//   - pop_err clears only on rst.
//   - If a push occurs in the same cycle, count -> 1 and pop_err still sets.
// - Count never exceeds N; push is masked when full, so overflow is impossible.
// - Requester rules:
//   - A requester may drop i_req_vld without a grant (arbiter holds no state for it).
//   - Payload is sampled only on the accepting cycle.
// - Reset mid-traffic: in-flight grants are dropped, count returns to 0.
//   - The queue controller must be reset in the same cycle.
// CONFIGURATION
// - QUEUE_PUSH_ARB_BURST_EN defined:
//   - After a push with i_req_last[winner]=0, the arbiter locks to that requester.
//   - While locked, only that requester can be granted; others see rdy=0.
//   - The lock survives full or vld gaps.
//   - The lock releases on the accepted beat with i_req_last=1.
//   - rr_ptr advances only on release.
//   - i_req_last of a non-granted requester is ignored.
// - QUEUE_PUSH_ARB_BURST_EN undefined:
//   - i_req_last port is present but unused.
//   - Arbitration is re-done every beat; rr_ptr advances on every push.
// TESTING (R=4, N=8, W=32)
// - Reset then idle: vld=0 for 10 cycles -> o_push=0, o_count=0, o_empty=1, o_full=0, o_pop_err=0.
// - Fairness: vld=4'b1111 for 8 cycles, no pop -> grants 0,1,2,3,0,1,2,3.
//   - Then o_count=8, o_full=1, rdy=0 on the following cycle.
// - Full + pop: at count=8 with vld=4'b0001, pop=1 for one cycle -> no grant that cycle, count=7.
//   - Next cycle: grant to requester 0, count=8.
// - Simultaneous push/pop: count=3, vld=4'b0100, pop=1 -> push src=2, count stays 3, rr_ptr=3.
// - Empty pop: count=0, pop=1, vld=0 -> count=0, o_pop_err=1 and stays 1 until rst.
// - BURST_EN: req1 sends 3 beats (last on beat 3) while req0,2 are valid.
//   - Grants are 1,1,1, then 2 (rr_ptr=2).
//   - Without the macro, the same stimulus grants 1,2,0,1,...

Source files
------------

// File: rtl/queue_push_arb_if.sv
// Push-side bus of queue_push_arb: R requester channels in, one queue push port out.
//   i_req_vld  [R]       per-requester valid
//   i_req_dat  [R*W]     per-requester payload, requester k at [k*W +: W]
//   i_req_last [R]       last beat of a burst (used only when bursts are enabled)
//   o_req_rdy  [R]       one-hot accept; a beat transfers on vld & rdy
//   o_push               push strobe to the queue controller / SRAM write port
//   o_push_dat [W]       payload of the granted requester
//   o_push_src [log2 R]  index of the granted requester
// Modports: master = requesters and queue side (drives requests), slave = arbiter.
interface queue_push_arb_if #(
    parameter int unsigned R = 4,
    parameter int unsigned W = 32
);
    localparam int unsigned SRC_W = $clog2(R);

    logic [R-1:0]     i_req_vld;
    logic [R*W-1:0]   i_req_dat;
    logic [R-1:0]     i_req_last;
    logic [R-1:0]     o_req_rdy;
    logic             o_push;
    logic [W-1:0]     o_push_dat;
    logic [SRC_W-1:0] o_push_src;

    modport master (
        output i_req_vld,
        output i_req_dat,
        output i_req_last,
        input  o_req_rdy,
        input  o_push,
        input  o_push_dat,
        input  o_push_src
    );

    modport slave (
        input  i_req_vld,
        input  i_req_dat,
        input  i_req_last,
        output o_req_rdy,
        output o_push,
        output o_push_dat,
        output o_push_src
    );
endinterface

// File: rtl/queue_push_arb.sv
// Round-robin arbiter sharing one queue controller push port between R requesters.
// Tracks queue occupancy itself so a grant can never overrun the queue; the pop side
// is only observed to return credit.
//   clk, rst     clock, synchronous active-high reset
//   bus          queue_push_arb_if slave: request channels in, push port out
//   i_pop        pop strobe seen by the queue controller
//   o_count      registered occupancy (0..N)
//   o_full       o_count == N
//   o_empty      o_count == 0
//   o_pop_err    sticky: pop seen while empty, cleared only by rst
// Optional feature: define QUEUE_PUSH_ARB_BURST_EN to keep a grant locked to one
// requester until it presents i_req_last on an accepted beat.
module queue_push_arb #(
    parameter int unsigned R = 4,
    parameter int unsigned N = 8,
    parameter int unsigned W = 32,
    localparam int unsigned CNT_W = $clog2(N) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    queue_push_arb_if.slave        bus,
    input  logic                   i_pop,
    output logic [CNT_W-1:0]       o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_pop_err
);
    localparam int unsigned SRC_W = $clog2(R);

    // (base + off) mod R; R need not be a power of two, so wrap explicitly.
    function automatic logic [SRC_W-1:0] wrap_add(logic [SRC_W-1:0] base, int unsigned off);
        logic [SRC_W:0] sum;
        sum = {1'b0, base} + (SRC_W + 1)'(off);
        if (sum >= (SRC_W + 1)'(R)) begin
            sum = sum - (SRC_W + 1)'(R);
        end
        return sum[SRC_W-1:0];
    endfunction

    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_err_q, pop_err_d;
    logic [SRC_W-1:0] winner;
    logic             winner_vld;
    logic             grant;
    logic             pop_eff;
    logic             full;
`ifdef QUEUE_PUSH_ARB_BURST_EN
    logic             lock_q, lock_d;
    logic [SRC_W-1:0] lock_src_q, lock_src_d;
`endif

    assign full = (count_q == CNT_W'(N));

    // Winner: first valid requester scanning from rr_ptr upward, modulo R.
    always_comb begin
        logic [SRC_W-1:0] idx;
        winner_vld = 1'b0;
        winner     = '0;
        idx        = '0;
        for (int unsigned i = 0; i < R; i++) begin
            idx = wrap_add(rr_ptr_q, i);
            if (!winner_vld && bus.i_req_vld[idx]) begin
                winner_vld = 1'b1;
                winner     = idx;
            end
        end
`ifdef QUEUE_PUSH_ARB_BURST_EN
        // A locked burst owner is the only candidate, even across vld gaps.
        if (lock_q) begin
            winner     = lock_src_q;
            winner_vld = bus.i_req_vld[lock_src_q];
        end
`endif
    end

    // No bypass: a pop in the same cycle does not unmask a full queue.
    assign grant = winner_vld && !full && !rst;

    always_comb begin
        bus.o_req_rdy  = '0;
        bus.o_push_dat = '0;
        for (int unsigned k = 0; k < R; k++) begin
            bus.o_req_rdy[k] = grant && (winner == SRC_W'(k));
            if (winner == SRC_W'(k)) begin
                bus.o_push_dat = bus.i_req_dat[k*W +: W];
            end
        end
        bus.o_push     = grant;
        bus.o_push_src = winner;
    end

    // Next-state: occupancy, sticky error, round-robin pointer, burst lock.
    always_comb begin
        logic [CNT_W-1:0] delta;
        pop_eff   = i_pop && (count_q != '0);
        pop_err_d = pop_err_q || (i_pop && (count_q == '0));
        delta     = '0;
        if (grant && !pop_eff) begin
            delta = CNT_W'(1);
        end else if (pop_eff && !grant) begin
            delta = '1;
        end
        count_d  = count_q + delta;
        rr_ptr_d = rr_ptr_q;
`ifdef QUEUE_PUSH_ARB_BURST_EN
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (grant) begin
            if (bus.i_req_last[winner]) begin
                lock_d   = 1'b0;
                rr_ptr_d = wrap_add(winner, 1);
            end else begin
                lock_d     = 1'b1;
                lock_src_d = winner;
            end
        end
`else
        if (grant) begin
            rr_ptr_d = wrap_add(winner, 1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            count_q    <= '0;
            pop_err_q  <= 1'b0;
`ifdef QUEUE_PUSH_ARB_BURST_EN
            lock_q     <= 1'b0;
            lock_src_q <= '0;
`endif
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            count_q    <= count_d;
            pop_err_q  <= pop_err_d;
`ifdef QUEUE_PUSH_ARB_BURST_EN
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
`endif
        end
    end

    assign o_count   = count_q;
    assign o_full    = full;
    assign o_empty   = (count_q == '0);
    assign o_pop_err = pop_err_q;
endmodule
